// File: rtl/bus_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : bus_apb_bridge
// Description : Single-outstanding bus to APB bridge with pready timeout abort.
// Revision    : 1.0
// ============================================================================

module bus_apb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic                    busy,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    err,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic                    pready,
    input  logic                    pslverr,
    input  logic [DATA_WIDTH-1:0]   prdata
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_count;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_W-1:0]     r_pstrb;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_err;

    logic w_accept;
    logic w_done;
    logic w_timeout;

    assign w_accept  = en && (r_state == S_IDLE);
    assign w_done    = (r_state == S_ACCESS) && pready;
    // pready on the final allowed cycle wins over the abort
    assign w_timeout = (r_state == S_ACCESS) && !pready && (r_count == C_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_state <= S_ACCESS;
                    r_count <= '0;
                end
                S_ACCESS: begin
                    if (w_done || w_timeout) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_count <= r_count + C_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Request fields are captured once and stay frozen for the whole transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_pwrite <= 1'b0;
        end else if (w_accept) begin
            r_paddr  <= addr;
            r_pwdata <= din;
            r_pstrb  <= we;
            r_pwrite <= |we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err  <= 1'b0;
            r_dout <= '0;
        end else begin
            r_err <= 1'b0;
            if (w_done) begin
                r_err <= pslverr;
                if (!r_pwrite) begin
                    r_dout <= prdata;
                end
            end else if (w_timeout) begin
                r_err <= 1'b1;
                if (!r_pwrite) begin
                    r_dout <= '0;
                end
            end
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign psel    = (r_state != S_IDLE);
    assign penable = (r_state == S_ACCESS);
    assign pwrite  = r_pwrite;
    assign paddr   = r_paddr;
    assign pwdata  = r_pwdata;
    assign pstrb   = r_pstrb;
    assign pprot   = 3'b000;
    assign dout    = r_dout;
    assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bus_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_apb_bridge
// Description : Self-checking bench for bus_apb_bridge (TIMEOUT_CYCLES = 4).
// Revision    : 1.0
// ============================================================================

module tb_bus_apb_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [3:0]    we = '0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din = '0;
    logic          busy;
    logic [DW-1:0] dout;
    logic          err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic          pready;
    logic          pslverr;
    logic [DW-1:0] prdata;

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] exp_dout = '0;

    // Completer behaviour: answers after wait_n stalled ACCESS cycles
    int            wait_n = 0;
    logic          slverr_v = 1'b0;
    logic [DW-1:0] rdata_v = '0;
    int            acc_cnt;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_cnt <= 0;
        else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    assign pready  = psel && penable && (acc_cnt >= wait_n);
    assign pslverr = pready && slverr_v;
    assign prdata  = rdata_v;

    bus_apb_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .din(din),
        .busy(busy), .dout(dout), .err(err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer; the expected outcome comes from the transfer rules:
    // w < TO completes after 2+w busy cycles, otherwise aborts after TO ACCESS cycles.
    task automatic do_xfer(input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                           input int w, input logic e, input logic [31:0] rd, input string nm);
        int busy_cnt = 0;
        int pen_cnt = 0;
        int guard = 0;
        int exp_busy;
        int exp_pen;
        logic exp_err;
        wait_n = w; slverr_v = e; rdata_v = rd;
        en = 1'b1; we = s; addr = a; din = d;
        tick();
        en = 1'b0; we = 4'($urandom); addr = $urandom; din = $urandom;
        while (busy && guard < 64) begin
            busy_cnt++;
            if (penable) pen_cnt++;
            vectors++;
            if (psel !== 1'b1 || paddr !== a || pwdata !== d || pstrb !== s || pwrite !== (s != 0)) begin
                miscompares++;
                $display("FAIL %s hold: psel=%b paddr=%h pwdata=%h pstrb=%b pwrite=%b, wanted 1 %h %h %b %b",
                         nm, psel, paddr, pwdata, pstrb, pwrite, a, d, s, (s != 0));
            end
            tick();
            guard++;
        end
        if (guard >= 64) begin
            miscompares++;
            $display("FAIL %s busy_bound: busy still %b after 64 cycles, wanted 0", nm, busy);
        end
        if (w >= TO) begin
            exp_busy = 1 + TO; exp_pen = TO; exp_err = 1'b1;
            if (s == 0) exp_dout = '0;
        end else begin
            exp_busy = 2 + w; exp_pen = 1 + w; exp_err = e;
            if (s == 0) exp_dout = rd;
        end
        vectors++;
        if (busy_cnt != exp_busy || pen_cnt != exp_pen) begin
            miscompares++;
            $display("FAIL %s cycles: busy=%0d penable=%0d, wanted %0d %0d", nm, busy_cnt, pen_cnt, exp_busy, exp_pen);
        end
        vectors++;
        if (err !== exp_err || dout !== exp_dout || psel !== 1'b0 || penable !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done: err=%b dout=%h psel=%b penable=%b, wanted %b %h 0 0",
                     nm, err, dout, psel, penable, exp_err, exp_dout);
        end
        tick();
        vectors++;
        if (err !== 1'b0 || paddr !== a || dout !== exp_dout) begin
            miscompares++;
            $display("FAIL %s after: err=%b paddr=%h dout=%h, wanted 0 %h %h", nm, err, paddr, dout, a, exp_dout);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if (busy !== 1'b0 || psel !== 1'b0 || penable !== 1'b0 || pwrite !== 1'b0 || paddr !== '0 ||
            pwdata !== '0 || pstrb !== '0 || dout !== '0 || err !== 1'b0 || pprot !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_values: busy=%b psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h pstrb=%b dout=%h err=%b pprot=%b, wanted all 0",
                     busy, psel, penable, pwrite, paddr, pwdata, pstrb, dout, err, pprot);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_dout = '0;
    endtask

    task automatic test_read_zero_wait();
        do_xfer(4'b0000, 32'h10, 32'h0, 0, 1'b0, 32'hDEADBEEF, "read_zero_wait");
    endtask

    task automatic test_write_wait();
        do_xfer(4'b0011, 32'h20, 32'h12345678, 2, 1'b0, 32'hCAFEF00D, "write_wait2");
    endtask

    task automatic test_slverr();
        do_xfer(4'b1111, 32'h30, 32'hA5A5_0F0F, 0, 1'b1, 32'h0, "write_slverr");
        do_xfer(4'b0000, 32'h34, 32'h0, 1, 1'b1, 32'h7777_8888, "read_slverr");
    endtask

    task automatic test_timeout();
        do_xfer(4'b0000, 32'h44, 32'h0, TO - 1, 1'b0, 32'h1234_ABCD, "read_last_cycle");
        do_xfer(4'b0000, 32'h48, 32'h0, 1000, 1'b0, 32'hFFFF_FFFF, "read_timeout");
        do_xfer(4'b0100, 32'h4C, 32'h0BAD_0BAD, 1000, 1'b0, 32'h0, "write_timeout");
    endtask

    task automatic test_back_to_back();
        logic [6:0] pat = 7'b0001101;
        int setups = 0;
        bit setup_now;
        wait_n = 0; slverr_v = 1'b0; rdata_v = 32'h1111_2222;
        en = 1'b1; we = 4'b0000; addr = 32'h50;
        for (int i = 0; i < 9; i++) begin
            tick();
            setup_now = psel && !penable;
            vectors++;
            if (setup_now !== (i % 3 == 0)) begin
                miscompares++;
                $display("FAIL b2b_setup[%0d]: setup=%b, wanted %b", i, setup_now, (i % 3 == 0));
            end
        end
        en = 1'b0;
        exp_dout = 32'h1111_2222;
        tick();
        vectors++;
        if (busy !== 1'b0 || dout !== exp_dout) begin
            miscompares++;
            $display("FAIL b2b_end: busy=%b dout=%h, wanted 0 %h", busy, dout, exp_dout);
        end
        wait_n = 2;
        en = 1'b1; we = 4'b1000; addr = 32'h54; din = 32'h5555_6666;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (psel && !penable) setups++;
            vectors++;
            if (busy !== (i < 4)) begin
                miscompares++;
                $display("FAIL ignored_en_busy[%0d]: busy=%b, wanted %b", i, busy, (i < 4));
            end
            en = pat[i];
        end
        vectors++;
        if (setups != 1) begin
            miscompares++;
            $display("FAIL ignored_en_count: setups=%0d, wanted 1", setups);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [3:0] s = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            do_xfer(s, $urandom, $urandom, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                    $urandom, "random");
        end
    endtask

    task automatic test_reset_in_access();
        do_xfer(4'b0000, 32'h60, 32'h0, 0, 1'b0, 32'hA5A5_A5A5, "pre_reset_read");
        wait_n = 1000;
        en = 1'b1; we = 4'b0000; addr = 32'h64;
        tick();
        en = 1'b0;
        tick();
        vectors++;
        if (penable !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_access_entry: penable=%b, wanted 1", penable);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_dout = '0;
        vectors++;
        if (psel !== 1'b0 || penable !== 1'b0 || busy !== 1'b0 || dout !== '0 || paddr !== '0 || pwrite !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async: psel=%b penable=%b busy=%b dout=%h paddr=%h pwrite=%b, wanted all 0",
                     psel, penable, busy, dout, paddr, pwrite);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_xfer(4'b0000, 32'h68, 32'h0, 1, 1'b0, 32'h600D_D00D, "read_after_reset");
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_in_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
